gpu_host_loader: RTL and testbench
==================================

Name: gpu_host_loader

Overview:
- Host-side command engine that loads programs and data into the single-cycle GPU and reads results back, replacing hierarchical backdoor pokes.
- Accepts a 32-bit command stream over valid/ready and drives instruction-memory and data-memory write ports.
- Streams data-memory contents out over a valid/ready response channel.
- Gates GPU execution with `gpu_run` for a commanded number of cycles. It sits between the host link and the gpu_top memory/run muxes.

Parameters:
- IMEM_DEPTH, 256, instruction memory words; IA_W = $clog2(IMEM_DEPTH).
- DMEM_DEPTH, 256, data memory words; DA_W = $clog2(DMEM_DEPTH).
- INSTR_W, 32, instruction word width.
- DATA_W, 16, data/register word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command word valid.
- cmd_ready  out  1  loader accepts cmd_data this cycle.
- cmd_data  in  32  header or payload word.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  DATA_W  response word.
- imem_we  out  1  instruction write strobe.
- imem_addr  out  IA_W  instruction write address.
- imem_wdata  out  INSTR_W  instruction write data.
- dmem_we  out  1  data write strobe.
- dmem_re  out  1  data read strobe.
- dmem_addr  out  DA_W  data address.
- dmem_wdata  out  DATA_W  data write data.
- dmem_rdata  in  DATA_W  read data, valid the cycle after dmem_re.
- gpu_run  out  1  1 = GPU core enabled; 0 = GPU held and memories owned by the loader.
- err  out  1  sticky bad-opcode flag.

Behaviour:
- **Reset** (reset==0 at posedge): state IDLE. All outputs are 0 except cmd_ready, which is 1. Counters and err are cleared. A reset mid-command aborts it: partial writes remain in memory, and a pending response is dropped.
- **Header word**: [31:28] op, [27:16] count, [15:0] base address, truncated to IA_W/DA_W.
- **Op codes**: 1 = WR_IMEM, 2 = WR_DMEM, 3 = RD_DMEM, 4 = RUN.
  - Any other op: header consumed, err set, stay in IDLE.
- **IDLE**: cmd_ready=1. A handshake latches op/count/addr and moves to the op state.
  - count==0: WR_IMEM, WR_DMEM and RD_DMEM return to IDLE with no memory activity. RUN still emits its response (see RUN).
- **WR_IMEM / WR_DMEM**: cmd_ready=1. Each payload handshake drives the matching we=1 for exactly that cycle (registered strobe, one cycle after the handshake).
  - imem_wdata = cmd_data; dmem_wdata = cmd_data[15:0].
  - Address increments after each write and wraps modulo depth.
  - After the count-th write, return to IDLE.
- **RD_DMEM**: cmd_ready=0.
  - RD_ISSUE: dmem_re=1 for one cycle.
  - RD_CAP: latch dmem_rdata into rsp_data, rsp_valid=1.
  - RD_SEND: hold rsp_data stable until rsp_ready. On handshake, increment address with wrap and decrement remaining count. Go to RD_ISSUE, or to IDLE after the last word.
  - Maximum throughput is one word per 3 cycles.
- **RUN**: cmd_ready=0. gpu_run=1 for exactly count cycles, counted by a down counter.
  - Then gpu_run=0, and a response of {4'hD, count[11:0]} is emitted in RUN_RSP and held until rsp_ready.
  - count==0: gpu_run never asserts; the response is 16'hD000.
- **Port ownership**:
  - imem_we, dmem_we and dmem_re are never asserted while gpu_run=1.
  - rsp_valid, once raised, is never dropped before handshake, and rsp_data does not change while rsp_valid=1.
- A cmd_valid that arrives while cmd_ready=0 is held by the host, not lost.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - WR_IMEM/WR_DMEM accumulate a 16-bit XOR of every payload word (instruction words fold as data[31:16]^data[15:0]).
  - After the last payload word, the loader enters WR_RSP and emits the checksum on rsp before IDLE.
  - count==0 emits 16'h0000.
- Undefined: writes produce no response.

Decomposition:
- Package gpu_loader_pkg: op-code enum (OP_WR_IMEM=4'h1, OP_WR_DMEM=4'h2, OP_RD_DMEM=4'h3, OP_RUN=4'h4), state enum, header field positions, RUN_RSP_TAG=4'hD.
- One natural sub-module: gpu_loader_rsp_reg, a response holding register enforcing the valid/ready stability rules.

Test Plan:
- Header 0x1_003_0000, then 0x00000312, 0x00001412, 0x00002522 -> imem_we pulses 3×, addresses 0, 1, 2, data matching.
- WR_DMEM base 0x00FE, count 3, data 15/100/7 -> dmem writes at 254, 255, 0 (wrap).
- RD_DMEM count 3 from addr 0 with memory {15,100,15}, rsp_ready toggling 1-0-0-1 -> rsp 15, 100, 15 in order, data stable while stalled, dmem_re never overlaps gpu_run.
- RUN count 15 -> gpu_run high exactly 15 cycles, response 0xD00F. RUN count 0 -> no gpu_run, response 0xD000.
- Header op 0x9 -> err=1 and stays 1. A following valid WR_IMEM still executes. Reset mid-RD_DMEM -> rsp_valid=0 next cycle, state IDLE, err=0.
- With LOADER_CHECKSUM_EN: WR_DMEM {0x00FF, 0x0F0F} -> checksum response 0x0FF0.

Source files
------------

// File: rtl/gpu_loader_pkg.sv
// Shared types and constants for the GPU host loader: header layout, op codes, FSM states.
// LOADER_CHECKSUM_EN (optional) adds an XOR checksum response after each write command.
package gpu_loader_pkg;

    localparam int unsigned IMEM_DEPTH   = 256;
    localparam int unsigned DMEM_DEPTH   = 256;
    localparam int unsigned IA_W         = $clog2(IMEM_DEPTH);
    localparam int unsigned DA_W         = $clog2(DMEM_DEPTH);
    localparam int unsigned AW           = (IA_W > DA_W) ? IA_W : DA_W;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned CMD_W        = 32;
    localparam int unsigned OP_W         = 4;
    localparam int unsigned CNT_W        = 12;
    localparam int unsigned BASE_W       = 16;
    localparam int unsigned HDR_OP_LSB   = 28;
    localparam int unsigned HDR_CNT_LSB  = 16;
    localparam int unsigned HDR_BASE_LSB = 0;

    localparam logic [OP_W-1:0] RUN_RSP_TAG = 4'hD;

    typedef enum logic [OP_W-1:0] {
        OP_WR_IMEM = 4'h1,
        OP_WR_DMEM = 4'h2,
        OP_RD_DMEM = 4'h3,
        OP_RUN     = 4'h4
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_IMEM,
        S_WR_DMEM,
        S_RD_ISSUE,
        S_RD_CAP,
        S_RD_SEND,
        S_RUN,
        S_RUN_RSP,
        S_WR_RSP
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [CNT_W-1:0]  count;
        logic [BASE_W-1:0] base;
    } hdr_t;

    // Address increment wrapping modulo the memory depth.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a, input int unsigned depth);
        return (32'(a) == depth - 1) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [DATA_W-1:0] fold_instr(input logic [INSTR_W-1:0] w);
        return w[31:16] ^ w[15:0];
    endfunction

endpackage

// File: rtl/gpu_loader_rsp_reg.sv
// Response holding register: once valid is raised, valid and data stay put until accepted.
module gpu_loader_rsp_reg
    import gpu_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // A load while a word is still pending is ignored so the held word cannot change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (r_valid) begin
            if (i_ready) begin
                r_valid <= 1'b0;
            end
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/gpu_host_loader.sv
// Host command engine: loads IMEM/DMEM, reads DMEM back and gates GPU execution.
// Optional LOADER_CHECKSUM_EN: write commands end with an XOR checksum response.
module gpu_host_loader
    import gpu_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CMD_W-1:0]   cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               imem_we,
    output logic [IA_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    output logic [DA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               gpu_run,
    output logic               err
);

    state_e             r_state,      w_state_nxt;
    logic [AW-1:0]      r_addr,       w_addr_nxt;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_nxt;
    logic [CNT_W-1:0]   r_hdr_cnt,    w_hdr_cnt_nxt;
    logic               r_cmd_ready,  w_cmd_ready_nxt;
    logic               r_imem_we,    w_imem_we_nxt;
    logic [IA_W-1:0]    r_imem_addr,  w_imem_addr_nxt;
    logic [INSTR_W-1:0] r_imem_wdata, w_imem_wdata_nxt;
    logic               r_dmem_we,    w_dmem_we_nxt;
    logic               r_dmem_re,    w_dmem_re_nxt;
    logic [DA_W-1:0]    r_dmem_addr,  w_dmem_addr_nxt;
    logic [DATA_W-1:0]  r_dmem_wdata, w_dmem_wdata_nxt;
    logic               r_gpu_run,    w_gpu_run_nxt;
    logic               r_err,        w_err_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]  r_csum,       w_csum_nxt;
`endif

    hdr_t              w_hdr;
    logic              w_cmd_hs;
    logic              w_rsp_hs;
    logic              w_rsp_load;
    logic [DATA_W-1:0] w_rsp_wdata;
    logic              w_unused_base;

    assign w_hdr         = hdr_t'(cmd_data);
    assign w_cmd_hs      = cmd_valid & r_cmd_ready;
    assign w_rsp_hs      = rsp_valid & rsp_ready;
    assign w_unused_base = ^w_hdr.base;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_hdr_cnt    <= '0;
            r_cmd_ready  <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_re    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_gpu_run    <= 1'b0;
            r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hdr_cnt    <= w_hdr_cnt_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_imem_we    <= w_imem_we_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_imem_wdata <= w_imem_wdata_nxt;
            r_dmem_we    <= w_dmem_we_nxt;
            r_dmem_re    <= w_dmem_re_nxt;
            r_dmem_addr  <= w_dmem_addr_nxt;
            r_dmem_wdata <= w_dmem_wdata_nxt;
            r_gpu_run    <= w_gpu_run_nxt;
            r_err        <= w_err_nxt;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= w_csum_nxt;
`endif
        end
    end

    // Next-state and next-output logic; strobes default low, data registers hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_cnt_nxt        = r_cnt;
        w_hdr_cnt_nxt    = r_hdr_cnt;
        w_imem_we_nxt    = 1'b0;
        w_imem_addr_nxt  = r_imem_addr;
        w_imem_wdata_nxt = r_imem_wdata;
        w_dmem_we_nxt    = 1'b0;
        w_dmem_re_nxt    = 1'b0;
        w_dmem_addr_nxt  = r_dmem_addr;
        w_dmem_wdata_nxt = r_dmem_wdata;
        w_gpu_run_nxt    = 1'b0;
        w_err_nxt        = r_err;
        w_rsp_load       = 1'b0;
        w_rsp_wdata      = '0;
`ifdef LOADER_CHECKSUM_EN
        w_csum_nxt       = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    w_cnt_nxt     = w_hdr.count;
                    w_hdr_cnt_nxt = w_hdr.count;
`ifdef LOADER_CHECKSUM_EN
                    w_csum_nxt    = '0;
`endif
                    case (w_hdr.op)
                        OP_WR_IMEM, OP_WR_DMEM: begin
                            w_addr_nxt = (w_hdr.op == OP_WR_IMEM) ? AW'(w_hdr.base[IA_W-1:0])
                                                                  : AW'(w_hdr.base[DA_W-1:0]);
                            if (w_hdr.count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                w_rsp_load  = 1'b1;
                                w_state_nxt = S_WR_RSP;
`else
                                w_state_nxt = S_IDLE;
`endif
                            end else begin
                                w_state_nxt = (w_hdr.op == OP_WR_IMEM) ? S_WR_IMEM : S_WR_DMEM;
                            end
                        end
                        OP_RD_DMEM: begin
                            w_addr_nxt = AW'(w_hdr.base[DA_W-1:0]);
                            if (w_hdr.count != '0) begin
                                w_state_nxt     = S_RD_ISSUE;
                                w_dmem_re_nxt   = 1'b1;
                                w_dmem_addr_nxt = w_hdr.base[DA_W-1:0];
                            end
                        end
                        OP_RUN: begin
                            if (w_hdr.count == '0) begin
                                w_rsp_load  = 1'b1;
                                w_rsp_wdata = DATA_W'({RUN_RSP_TAG, w_hdr.count});
                                w_state_nxt = S_RUN_RSP;
                            end else begin
                                w_gpu_run_nxt = 1'b1;
                                w_state_nxt   = S_RUN;
                            end
                        end
                        default: w_err_nxt = 1'b1;
                    endcase
                end
            end
            S_WR_IMEM, S_WR_DMEM: begin
                if (w_cmd_hs) begin
                    if (r_state == S_WR_IMEM) begin
                        w_imem_we_nxt    = 1'b1;
                        w_imem_addr_nxt  = IA_W'(r_addr);
                        w_imem_wdata_nxt = cmd_data;
                        w_addr_nxt       = addr_inc(r_addr, IMEM_DEPTH);
`ifdef LOADER_CHECKSUM_EN
                        w_csum_nxt       = r_csum ^ fold_instr(cmd_data);
`endif
                    end else begin
                        w_dmem_we_nxt    = 1'b1;
                        w_dmem_addr_nxt  = DA_W'(r_addr);
                        w_dmem_wdata_nxt = cmd_data[DATA_W-1:0];
                        w_addr_nxt       = addr_inc(r_addr, DMEM_DEPTH);
`ifdef LOADER_CHECKSUM_EN
                        w_csum_nxt       = r_csum ^ cmd_data[DATA_W-1:0];
`endif
                    end
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        w_rsp_load  = 1'b1;
                        w_rsp_wdata = w_csum_nxt;
                        w_state_nxt = S_WR_RSP;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_CAP;
            S_RD_CAP: begin
                w_rsp_load  = 1'b1;
                w_rsp_wdata = dmem_rdata;
                w_state_nxt = S_RD_SEND;
            end
            S_RD_SEND: begin
                if (w_rsp_hs) begin
                    w_addr_nxt = addr_inc(r_addr, DMEM_DEPTH);
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt     = S_RD_ISSUE;
                        w_dmem_re_nxt   = 1'b1;
                        w_dmem_addr_nxt = DA_W'(w_addr_nxt);
                    end
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_rsp_load  = 1'b1;
                    w_rsp_wdata = DATA_W'({RUN_RSP_TAG, r_hdr_cnt});
                    w_state_nxt = S_RUN_RSP;
                end else begin
                    w_gpu_run_nxt = 1'b1;
                end
            end
            S_RUN_RSP, S_WR_RSP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_WR_IMEM) ||
                          (w_state_nxt == S_WR_DMEM);
    end

    gpu_loader_rsp_reg u_rsp_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_rsp_load),
        .i_data  (w_rsp_wdata),
        .i_ready (rsp_ready),
        .o_valid (rsp_valid),
        .o_data  (rsp_data)
    );

    assign cmd_ready  = r_cmd_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign dmem_we    = r_dmem_we;
    assign dmem_re    = r_dmem_re;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign gpu_run    = r_gpu_run;
    assign err        = r_err;

endmodule

// File: tb/tb_gpu_host_loader.sv
// Scoreboard bench for gpu_host_loader: a command-level model predicts memory writes,
// responses and run lengths; a negedge monitor compares whatever the DUT presents.
module tb_gpu_host_loader;
    import gpu_loader_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [31:0]        cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [DATA_W-1:0]  rsp_data;
    logic               imem_we;
    logic [IA_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               dmem_we;
    logic               dmem_re;
    logic [DA_W-1:0]    dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata = '0;
    logic               gpu_run;
    logic               err;

    always #5 clk = ~clk;

    gpu_host_loader dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .gpu_run    (gpu_run),
        .err        (err)
    );

    // Data memory the DUT actually drives (read data valid the cycle after dmem_re).
    logic [DATA_W-1:0] phys_dmem [DMEM_DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (dmem_we) phys_dmem[dmem_addr] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= phys_dmem[dmem_addr];
    end

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q_imem[$];
    wr_t         q_dmem[$];
    logic [15:0] q_rsp[$];
    int unsigned q_run[$];
    logic [31:0] payload[$];
    logic [15:0] ref_dmem [DMEM_DEPTH] = '{default: '0};
    logic        ref_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // rsp_ready policy: 0 = hold off, 1 = random, 2 = repeating 1-0-0-1, other = always ready.
    int   rdy_mode = 3;
    int   rdy_idx  = 0;
    logic pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    rsp_ready = pat[rdy_idx % 4];
                    rdy_idx++;
                end
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pop and compare each observed write, response and run window.
    logic              prev_v = 1'b0;
    logic              prev_hs = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    int unsigned       run_len = 0;
    always @(negedge clk) begin : mon
        wr_t e;
        if (!reset) begin
            prev_v  <= 1'b0;
            run_len <= 0;
        end else begin
            if (imem_we) begin
                if (q_imem.size() == 0) check("imem_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
                else begin
                    e = q_imem.pop_front();
                    check("imem_addr", 32'(imem_addr), e.addr);
                    check("imem_data", imem_wdata, e.data);
                end
            end
            if (dmem_we) begin
                if (q_dmem.size() == 0) check("dmem_unexpected", 32'(dmem_addr), 32'hFFFF_FFFF);
                else begin
                    e = q_dmem.pop_front();
                    check("dmem_addr", 32'(dmem_addr), e.addr);
                    check("dmem_data", 32'(dmem_wdata), e.data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (q_rsp.size() == 0) check("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
                else check("rsp_data", 32'(rsp_data), 32'(q_rsp.pop_front()));
            end
            if (prev_v && !prev_hs)
                check("rsp_hold", {15'b0, rsp_valid, rsp_data}, {15'b0, 1'b1, prev_d});
            prev_v  <= rsp_valid;
            prev_d  <= rsp_data;
            prev_hs <= rsp_valid && rsp_ready;
            if (gpu_run) begin
                check("port_own", 32'({imem_we, dmem_we, dmem_re}), 32'h0);
                run_len <= run_len + 1;
            end else begin
                if (run_len != 0) begin
                    if (q_run.size() == 0) check("run_unexpected", run_len, 32'h0);
                    else check("run_len", run_len, q_run.pop_front());
                end
                run_len <= 0;
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int   guard = 0;
        logic got = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        while (!got && guard < 3000) begin
            @(negedge clk);
            got = cmd_ready;
            guard++;
        end
        check("cmd_accept", 32'(got), 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic fill_random(input int unsigned n);
        payload.delete();
        for (int i = 0; i < int'(n); i++) payload.push_back($urandom);
    endtask

    // Command-level reference: expected effects are queued, then the words are sent.
    task automatic do_cmd(input logic [3:0] op, input int unsigned cnt, input logic [15:0] base);
        int unsigned a;
        logic [15:0] cs;
        cs = '0;
        case (op)
            4'h1: begin
                a = int'(base) % IMEM_DEPTH;
                for (int i = 0; i < int'(cnt); i++) begin
                    q_imem.push_back('{(a + i) % IMEM_DEPTH, payload[i]});
                    cs = cs ^ payload[i][31:16] ^ payload[i][15:0];
                end
            end
            4'h2: begin
                a = int'(base) % DMEM_DEPTH;
                for (int i = 0; i < int'(cnt); i++) begin
                    q_dmem.push_back('{(a + i) % DMEM_DEPTH, {16'h0, payload[i][15:0]}});
                    ref_dmem[(a + i) % DMEM_DEPTH] = payload[i][15:0];
                    cs = cs ^ payload[i][15:0];
                end
            end
            4'h3: begin
                a = int'(base) % DMEM_DEPTH;
                for (int i = 0; i < int'(cnt); i++) q_rsp.push_back(ref_dmem[(a + i) % DMEM_DEPTH]);
            end
            4'h4: begin
                if (cnt != 0) q_run.push_back(cnt);
                q_rsp.push_back(16'hD000 | 16'(cnt));
            end
            default: ref_err = 1'b1;
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (op == 4'h1 || op == 4'h2) q_rsp.push_back(cs);
`endif
        send_word({op, 12'(cnt), base});
        if (op == 4'h1 || op == 4'h2)
            for (int i = 0; i < int'(cnt); i++) send_word(payload[i]);
    endtask

    task automatic drain();
        int g = 0;
        while ((q_imem.size() + q_dmem.size() + q_rsp.size() + q_run.size()) != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(g < 5000), 32'h1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  rop;
        int unsigned rcnt;
        int          w;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_gpu_run", 32'(gpu_run), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_strobes", 32'({imem_we, dmem_we, dmem_re}), 32'h0);
        check("rst_data", {rsp_data, 8'h0, dmem_addr}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        payload = '{32'h0000_0312, 32'h0000_1412, 32'h0000_2522};
        do_cmd(4'h1, 3, 16'h0000);
        payload = '{32'd15, 32'd100, 32'd7};
        do_cmd(4'h2, 3, 16'h00FE);
        payload = '{32'd15, 32'd100, 32'd15};
        do_cmd(4'h2, 3, 16'h0000);
        drain();

        rdy_mode = 2;
        do_cmd(4'h3, 3, 16'h0000);
        drain();
        rdy_mode = 1;

        do_cmd(4'h4, 15, 16'h0000);
        do_cmd(4'h4, 0, 16'h1234);
        drain();

        do_cmd(4'h9, 5, 16'h0000);
        check("err_set", 32'(err), 32'(ref_err));
        fill_random(2);
        do_cmd(4'h1, 2, 16'h0150);
        drain();
        check("err_sticky", 32'(err), 32'(ref_err));

`ifdef LOADER_CHECKSUM_EN
        payload = '{32'h0000_00FF, 32'h0000_0F0F};
        do_cmd(4'h2, 2, 16'h0040);
        do_cmd(4'h1, 0, 16'h0000);
        drain();
`endif

        for (int i = 0; i < 30; i++) begin
            w = int'($urandom_range(0, 9));
            rop = (w == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(1, 4));
            rcnt = (rop == 4'h4) ? $urandom_range(0, 20) : $urandom_range(0, 6);
            fill_random(rcnt);
            do_cmd(rop, rcnt, 16'($urandom_range(0, 65535)));
        end
        drain();
        check("err_random", 32'(err), 32'(ref_err));

        // Reset in the middle of a read burst drops the pending response.
        rdy_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        do_cmd(4'h3, 4, 16'h00FD);
        w = 0;
        while (!rsp_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rd_valid_seen", 32'(rsp_valid), 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("midrst_err", 32'(err), 32'h0);
        q_rsp.delete();
        ref_err = 1'b0;
        rdy_mode = 1;

        fill_random(3);
        do_cmd(4'h2, 3, 16'h00FF);
        do_cmd(4'h3, 3, 16'h00FF);
        do_cmd(4'h4, 4, 16'h0000);
        drain();

        check("q_imem_empty", 32'(q_imem.size()), 32'h0);
        check("q_dmem_empty", 32'(q_dmem.size()), 32'h0);
        check("q_rsp_empty", 32'(q_rsp.size()), 32'h0);
        check("q_run_empty", 32'(q_run.size()), 32'h0);
        check("err_final", 32'(err), 32'(ref_err));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
